// File: rtl/welford_tuple_scheduler_pkg.sv
// rtl/welford_tuple_scheduler_pkg.sv - shared widths and FSM encoding for the Welford tuple scheduler
package welford_tuple_scheduler_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  function automatic int mean_width(input int datain_width, input int scaling);
    return datain_width + scaling + 1;
  endfunction

  function automatic int var_width(input int datain_width, input int scaling);
    return 2 * datain_width + scaling + 1;
  endfunction

  function automatic int tuple_width(input int res_short_width);
    return 4 * res_short_width;
  endfunction

endpackage

// File: rtl/welford_tuple_scheduler_packer.sv
// rtl/welford_tuple_scheduler_packer.sv - packs raw Welford stats into a four-field tuple
module welford_tuple_scheduler_packer #(
  parameter int SCALING         = 32,
  parameter int DATAIN_WIDTH    = 11,
  parameter int RES_SHORT_WIDTH = 24,
  parameter int MEAN_W          = DATAIN_WIDTH + SCALING + 1,
  parameter int VAR_W           = 2 * DATAIN_WIDTH + SCALING + 1
) (
  input  logic [RES_SHORT_WIDTH-1:0]   syn_cnt,
  input  logic [RES_SHORT_WIDTH-1:0]   pkt_cnt,
  input  logic [MEAN_W-1:0]            mean,
  input  logic [VAR_W-1:0]             variance,
  output logic [4*RES_SHORT_WIDTH-1:0] tuple
);

  logic [RES_SHORT_WIDTH-1:0] mean_f;
  logic [RES_SHORT_WIDTH-1:0] var_f;
  logic                       unused_bits;

  // Mean keeps only its integer magnitude bits; the sign bit is dropped.
  assign mean_f = {{(RES_SHORT_WIDTH-DATAIN_WIDTH){1'b0}},
                   mean[DATAIN_WIDTH+SCALING-1 -: DATAIN_WIDTH]};
  assign var_f  = variance[2*DATAIN_WIDTH+SCALING-1 -: RES_SHORT_WIDTH];
  assign tuple  = {syn_cnt, pkt_cnt, mean_f, var_f};

  assign unused_bits = ^{mean[MEAN_W-1], mean[SCALING-1:0], variance[VAR_W-1],
                         variance[2*DATAIN_WIDTH+SCALING-RES_SHORT_WIDTH-1:0]};

endmodule

// File: rtl/welford_tuple_scheduler_rr_arbiter.sv
// rtl/welford_tuple_scheduler_rr_arbiter.sv - combinational round-robin pick starting at ptr
module welford_tuple_scheduler_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  // Each slot's distance from ptr (mod NUM_REQ) is its priority; smallest wins.
  always_comb begin
    int best;
    int d;
    best  = NUM_REQ;
    d     = 0;
    idx   = '0;
    grant = '0;
    for (int s = 0; s < NUM_REQ; s++) begin
      d = s - int'(ptr);
      if (d < 0) d = d + NUM_REQ;
      if (req[s] && d < best) begin
        best = d;
        idx  = IDX_W'(s);
      end
    end
    any = (best < NUM_REQ);
    for (int s = 0; s < NUM_REQ; s++) begin
      grant[s] = any && (idx == IDX_W'(s));
    end
  end

endmodule

// File: rtl/welford_tuple_scheduler.sv
// rtl/welford_tuple_scheduler.sv - shares one tuple export path among NUM_REQ Welford engines
module welford_tuple_scheduler
  import welford_tuple_scheduler_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int SCALING         = 32,
  parameter int DATAIN_WIDTH    = 11,
  parameter int RES_SHORT_WIDTH = 24,
  parameter int CNT_WIDTH       = 32
) (
  input  logic                                         clk_lookup,
  input  logic                                         clk_lookup_rst,
  input  logic                                         enable,
  input  logic [NUM_REQ-1:0]                           req,
  input  logic [NUM_REQ*RES_SHORT_WIDTH-1:0]           syn_cnt_in,
  input  logic [NUM_REQ*RES_SHORT_WIDTH-1:0]           pkt_cnt_in,
  input  logic [NUM_REQ*(DATAIN_WIDTH+SCALING+1)-1:0]  mean_in,
  input  logic [NUM_REQ*(2*DATAIN_WIDTH+SCALING+1)-1:0] var_in,
  output logic [NUM_REQ-1:0]                           ack,
  output logic [4*RES_SHORT_WIDTH-1:0]                 tuple_out,
  output logic                                         tuple_valid,
  input  logic                                         tuple_ready,
  output logic [$clog2(NUM_REQ)-1:0]                   tuple_src,
  output logic [CNT_WIDTH-1:0]                         tuple_cnt
);

  localparam int MEAN_W  = mean_width(DATAIN_WIDTH, SCALING);
  localparam int VAR_W   = var_width(DATAIN_WIDTH, SCALING);
  localparam int TUPLE_W = tuple_width(RES_SHORT_WIDTH);
  localparam int IDX_W   = $clog2(NUM_REQ);

  state_t state, next_state;
  logic [IDX_W-1:0]           ptr;
  logic [IDX_W-1:0]           gnt_idx;
  logic [NUM_REQ-1:0]         gnt;
  logic                       gnt_any;
  logic                       grant_fire;
  logic                       accept;
  logic [RES_SHORT_WIDTH-1:0] sel_syn, sel_pkt, hold_syn, hold_pkt;
  logic [MEAN_W-1:0]          sel_mean, hold_mean;
  logic [VAR_W-1:0]           sel_var, hold_var;
  logic [TUPLE_W-1:0]         packed_tuple;

  welford_tuple_scheduler_rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .req   (req),
    .ptr   (ptr),
    .grant (gnt),
    .idx   (gnt_idx),
    .any   (gnt_any)
  );

  always_ff @(posedge clk_lookup or posedge clk_lookup_rst) begin
    if (clk_lookup_rst) state <= IDLE;
    else                state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (enable && gnt_any) next_state = SEND;
      SEND:    if (tuple_ready)       next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    grant_fire = (state == IDLE) && enable && gnt_any;
    accept     = (state == SEND) && tuple_valid && tuple_ready;
  end

  // One-hot grant drives an OR-mux over the flattened slot fields.
  always_comb begin
    sel_syn  = '0;
    sel_pkt  = '0;
    sel_mean = '0;
    sel_var  = '0;
    for (int s = 0; s < NUM_REQ; s++) begin
      if (gnt[s]) begin
        sel_syn  = sel_syn  | syn_cnt_in[s*RES_SHORT_WIDTH +: RES_SHORT_WIDTH];
        sel_pkt  = sel_pkt  | pkt_cnt_in[s*RES_SHORT_WIDTH +: RES_SHORT_WIDTH];
        sel_mean = sel_mean | mean_in[s*MEAN_W +: MEAN_W];
        sel_var  = sel_var  | var_in[s*VAR_W +: VAR_W];
      end
    end
  end

  always_ff @(posedge clk_lookup or posedge clk_lookup_rst) begin
    if (clk_lookup_rst) begin
      ack         <= '0;
      tuple_valid <= 1'b0;
      tuple_src   <= '0;
      tuple_cnt   <= '0;
      ptr         <= '0;
      hold_syn    <= '0;
      hold_pkt    <= '0;
      hold_mean   <= '0;
      hold_var    <= '0;
    end else begin
      ack <= grant_fire ? gnt : '0;
      if (grant_fire) begin
        hold_syn    <= sel_syn;
        hold_pkt    <= sel_pkt;
        hold_mean   <= sel_mean;
        hold_var    <= sel_var;
        tuple_src   <= gnt_idx;
        tuple_valid <= 1'b1;
        ptr         <= (gnt_idx == IDX_W'(NUM_REQ-1)) ? '0 : gnt_idx + IDX_W'(1);
      end
      if (accept) begin
        tuple_valid <= 1'b0;
        tuple_cnt   <= tuple_cnt + CNT_WIDTH'(1);
      end
    end
  end

  welford_tuple_scheduler_packer #(
    .SCALING         (SCALING),
    .DATAIN_WIDTH    (DATAIN_WIDTH),
    .RES_SHORT_WIDTH (RES_SHORT_WIDTH),
    .MEAN_W          (MEAN_W),
    .VAR_W           (VAR_W)
  ) u_pack (
    .syn_cnt  (hold_syn),
    .pkt_cnt  (hold_pkt),
    .mean     (hold_mean),
    .variance (hold_var),
    .tuple    (packed_tuple)
  );

  assign tuple_out = packed_tuple;

endmodule

// File: doc/welford_tuple_scheduler.md
Name: welford_tuple_scheduler

Overview:
Round-robin scheduler that shares one tuple-packing/export path among NUM_REQ Welford statistics engines.
- Each engine raises a request when its flow record is complete.
- The scheduler grants one engine, latches its raw stats and packs them into a 96-bit tuple.
- It presents the tuple on a valid/ready stream towards the digest/export logic and acknowledges the granted engine.
- Sits between the per-slot Welford update engines and the digest output of the extern.

Parameters:
NUM_REQ, 4, number of Welford engines sharing the export path (2..16)
SCALING, 32, fixed-point fractional bits of mean/variance
DATAIN_WIDTH, 11, integer width of the sampled quantity
RES_SHORT_WIDTH, 24, width of each packed tuple field
CNT_WIDTH, 32, width of the exported-tuple counter

Ports:
clk_lookup  in  1  clock
clk_lookup_rst  in  1  asynchronous active-high reset
enable  in  1  1 = grants allowed; 0 = no new grants, in-flight tuple completes
req  in  NUM_REQ  per-engine request, held until its ack
syn_cnt_in  in  NUM_REQ*RES_SHORT_WIDTH  flattened SYN counts, slot i at [i*W+:W]
pkt_cnt_in  in  NUM_REQ*RES_SHORT_WIDTH  flattened packet counts
mean_in  in  NUM_REQ*(DATAIN_WIDTH+SCALING+1)  flattened signed means
var_in  in  NUM_REQ*(2*DATAIN_WIDTH+SCALING+1)  flattened signed variances
ack  out  NUM_REQ  one-cycle one-hot pulse to the granted engine
tuple_out  out  4*RES_SHORT_WIDTH  packed tuple
tuple_valid  out  1  tuple_out valid
tuple_ready  in  1  downstream accept
tuple_src  out  clog2(NUM_REQ)  slot index of the current tuple
tuple_cnt  out  CNT_WIDTH  tuples accepted since reset, wraps

Behaviour:
- Reset values: state IDLE; ack=0, tuple_valid=0, tuple_out=0, tuple_src=0, tuple_cnt=0. The round-robin pointer resets so slot 0 has top priority.
- Clocking: every output is registered. Reset is asynchronous and clears all state immediately, including a tuple in flight that was not accepted (it is lost, no ack replay).
- Requester contract: the requester holds req[i] and keeps its stats inputs stable until ack[i]. It deasserts req[i] in the cycle after ack[i] unless it has a new record.
- FSM states: IDLE and SEND.
- IDLE, when enable=1 and req!=0 in cycle t:
  - Select the first requesting slot at or after the pointer, wrapping modulo NUM_REQ.
  - At edge t→t+1: capture that slot's four fields into the holding register, pulse ack[sel]=1 for cycle t+1 only, set tuple_src=sel and tuple_valid=1, move the pointer to sel+1 (wrap), and go to SEND.
- IDLE, when enable=0 or req==0: stay in IDLE with no ack.
- SEND: tuple_out, tuple_src and tuple_valid are held stable while tuple_ready=0.
- SEND, on tuple_valid & tuple_ready: increment tuple_cnt (wrapping) and go to IDLE, with tuple_valid=0 next cycle.
- Throughput: at most one tuple per 2 cycles. Grant latency is 1 cycle from req to ack/tuple_valid.
- enable falling while in SEND has no effect on the pending tuple.
- A req[i] that is still high in the cycle right after ack[i] (stale) is indistinguishable from a new record. The requester contract forbids this. The bench checks the contract; the RTL does not filter it.
- Packing: tuple_out = {syn, pkt, mean_f, var_f}, each field RES_SHORT_WIDTH bits.
  - syn and pkt: copied unchanged.
  - mean_f: zero-extended mean[DATAIN_WIDTH+SCALING-1 -: DATAIN_WIDTH], the integer part with the sign bit dropped.
  - var_f: var[2*DATAIN_WIDTH+SCALING-1 -: RES_SHORT_WIDTH].
  - Packing uses the existing Welford tuple-packing module on the registered fields, combinationally after the holding register, so it adds no latency.
- Fairness: a continuously requesting slot waits at most NUM_REQ-1 grants.

Decomposition:
- Shared package: field-width constants (MEAN_W = DATAIN_WIDTH+SCALING+1, VAR_W = 2*DATAIN_WIDTH+SCALING+1, TUPLE_W = 4*RES_SHORT_WIDTH) and the FSM state encoding (IDLE=0, SEND=1).
- Sub-module rr_arbiter: NUM_REQ request vector plus pointer in, one-hot grant and index out, purely combinational.
- The top level holds the FSM, the pointer register, the holding register, the counter and the packer instance.

Test Plan:
- Single request, slot 2: syn=5, pkt=100, mean=7<<32, var=3<<32, tuple_ready=1 → ack=4'b0100 one cycle after req; tuple_out=96'h000005_000064_000007_00000C; tuple_src=2; tuple_cnt=1.
- All four slots request continuously, tuple_ready=1 → grant order 0,1,2,3,0, one tuple every 2 cycles; tuple_cnt=5 after 10 cycles.
- Backpressure: tuple_ready=0 for 20 cycles → tuple_out and tuple_src stable, no further ack, tuple_cnt unchanged. Raising tuple_ready gives one accept, then return to IDLE.
- enable=0 with req=4'b1111 → no ack for 50 cycles. Dropping enable during SEND still completes the pending tuple.
- Asynchronous reset asserted mid-SEND → tuple_valid, ack and tuple_cnt are 0 immediately. After release the pointer restarts at slot 0.
- Negative mean (-1.5 in Q.32) → mean_f = 24'h0007FE, i.e. the low 11 integer bits zero-extended with the sign bit dropped.
